// File: rtl/mul_seq.sv
// ============================================================================
// mul_seq : sequential radix-2 shift-add multiplier, signed/unsigned, XLEN+1
//           cycle fixed latency with flush and hold-until-ack handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [XLEN-1:0]   opd1_i,
  input  logic [XLEN-1:0]   opd2_i,
  input  logic              flush_i,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] product_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [XLEN-1:0]   mcand_q,   mcand_d;
  logic [2*XLEN-1:0] acc_q,     acc_d;
  logic              neg_q,     neg_d;
  logic [2*XLEN-1:0] product_q, product_d;

  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN:0]   step_sum;
  logic            load;

  // The most-negative value negates to itself, which is exactly its unsigned magnitude.
  assign mag1 = (signed_i && opd1_i[XLEN-1]) ? (~opd1_i + XLEN'(1)) : opd1_i;
  assign mag2 = (signed_i && opd2_i[XLEN-1]) ? (~opd2_i + XLEN'(1)) : opd2_i;

  // Upper half accumulates; lower half starts as the multiplier and shifts out.
  assign step_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};

  assign load = !flush_i && start_i &&
                ((state_q == S_IDLE) || ((state_q == S_DONE) && ack_i));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CALC: begin
          if (cnt_q == '0) begin
            state_d   = S_DONE;
            product_d = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
          end else begin
            acc_d = {step_sum, acc_q[XLEN-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (ack_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (load) begin
      state_d = S_CALC;
      mcand_d = mag1;
      acc_d   = {{XLEN{1'b0}}, mag2};
      neg_d   = signed_i && (opd1_i[XLEN-1] ^ opd2_i[XLEN-1]);
      cnt_d   = CNT_W'(XLEN);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy_o    = (state_q == S_CALC);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;

endmodule

`default_nettype wire
